cla_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer that reuses one external 8-bit CLA slice (a/b/c_in in; g_out/p_out/s out)
//  to perform WIDTH-bit add/subtract, one byte per cycle, LSB first. Sits between the EX-stage

---
 rtl/cla_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_cla_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: sequences a WIDTH-bit add/subtract through one shared 8-bit
// CLA slice, one byte per cycle LSB first. The inter-byte carry lives here and
// is rebuilt from the slice's group generate/propagate, never from its sum.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE; resp_valid is high only in DONE,
// and resp_sum/resp_cout/resp_ovf hold stable until resp_ready is seen.
module cla_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf,
    output logic             busy,
    output logic [7:0]       slice_a,
    output logic [7:0]       slice_b,
    output logic             slice_cin,
    input  logic             slice_g,
    input  logic             slice_p,
    input  logic [7:0]       slice_s
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // Operands are consumed a byte at a time, so partial bytes cannot exist.
    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_seq_ctrl: WIDTH must be a positive multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;

    // Bit offset of the byte currently on the slice.
    logic [IDX_W+2:0] byte_lsb;
    assign byte_lsb = {idx, 3'b000};

    // Sequencer: accept, walk the bytes through the slice, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
                        a_reg <= req_a;
                        b_reg <= req_sub ? ~req_b : req_b;
                        carry <= req_sub;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[byte_lsb +: 8] <= slice_s;
                    carry                  <= slice_g | (slice_p & carry);
                    idx                    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and result outputs decoded from registered state only.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        busy       = (state == ST_RUN) || (state == ST_DONE);
        resp_valid = (state == ST_DONE);
        resp_sum   = '0;
        resp_cout  = 1'b0;
        resp_ovf   = 1'b0;
        if (state == ST_DONE) begin
            resp_sum  = sum_reg;
            resp_cout = carry;
            // Overflow: operands (effective B) agree in sign but the result does not.
            resp_ovf  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    // Slice operands are only presented while a byte is being processed.
    always_comb begin
        slice_a   = 8'h00;
        slice_b   = 8'h00;
        slice_cin = 1'b0;
        if (state == ST_RUN) begin
            slice_a   = a_reg[byte_lsb +: 8];
            slice_b   = b_reg[byte_lsb +: 8];
            slice_cin = carry;
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed bench for cla_seq_ctrl with a behavioural 8-bit
// CLA slice attached; expected results are hand-computed constants.
module tb_cla_seq_ctrl;

    localparam int W  = 32;
    localparam int EW = W + 2;   // {sum, cout, ovf}

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_sum;
    logic         resp_cout;
    logic         resp_ovf;
    logic         busy;
    logic [7:0]   slice_a;
    logic [7:0]   slice_b;
    logic         slice_cin;
    logic         slice_g;
    logic         slice_p;
    logic [7:0]   slice_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];
    logic          cin_q[$];

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_g    (slice_g),
        .slice_p    (slice_p),
        .slice_s    (slice_s)
    );

    // Behavioural shared CLA slice.
    logic [8:0] gen_sum;
    always_comb begin
        gen_sum = {1'b0, slice_a} + {1'b0, slice_b};
        slice_g = gen_sum[8];
        slice_p = &(slice_a ^ slice_b);
        slice_s = slice_a + slice_b + {7'd0, slice_cin};
    end

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected result and per-byte slice carry-ins (bit i = byte i).
    task automatic push_exp(input logic [W-1:0] s, input logic co, input logic ov,
                            input logic [3:0] cins);
        exp_q.push_back({s, co, ov});
        for (int i = 0; i < 4; i++) cin_q.push_back(cins[i]);
    endtask

    // One full operation with optional backpressure cycles in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int hold);
        logic [W-1:0]  b_eff;
        logic [EW-1:0] exp;
        int            cnt;
        b_eff = sub ? ~b : b;
        check({tag, "_req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        tick();
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            if (cnt < 4) begin
                check({tag, "_slice_a"}, slice_a, a[8*cnt +: 8]);
                check({tag, "_slice_b"}, slice_b, b_eff[8*cnt +: 8]);
                if (cin_q.size() > 0) check({tag, "_slice_cin"}, slice_cin, cin_q.pop_front());
            end
            tick();
            cnt++;
        end
        check({tag, "_latency"}, cnt, 4);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 1, 0);
            return;
        end
        exp = exp_q.pop_front();
        check({tag, "_sum"},  resp_sum,  exp[EW-1:2]);
        check({tag, "_cout"}, resp_cout, exp[1]);
        check({tag, "_ovf"},  resp_ovf,  exp[0]);
        check({tag, "_slice_idle"}, {slice_a, slice_b, slice_cin}, 17'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, resp_valid, 1'b1);
            check({tag, "_hold_res"}, {resp_sum, resp_cout, resp_ovf}, exp);
            check({tag, "_hold_req_ready"}, req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_back_idle"}, {req_ready, resp_valid, busy}, 3'b100);
        check({tag, "_resp_cleared"}, {resp_sum, resp_cout, resp_ovf}, '0);
    endtask

    // Three back-to-back ops with req_valid and resp_ready held high.
    task automatic pipe_test();
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic         ps [3];
        int k, done, cyc, last_acc;
        logic acc;
        pa[0] = 32'h1234_5678; pb[0] = 32'h1111_1111; ps[0] = 1'b0;
        pa[1] = 32'h00FF_00FF; pb[1] = 32'h0001_0001; ps[1] = 1'b0;
        pa[2] = 32'h0000_0100; pb[2] = 32'h0000_0001; ps[2] = 1'b1;
        push_exp(32'h2345_6789, 1'b0, 1'b0, 4'b0000);
        push_exp(32'h0100_0100, 1'b0, 1'b0, 4'b1010);
        push_exp(32'h0000_00FF, 1'b1, 1'b0, 4'b1101);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_a = pa[0]; req_b = pb[0]; req_sub = ps[0];
        k = 0; done = 0; cyc = 0; last_acc = 0;
        while (done < 3 && cyc < 100) begin
            acc = req_ready && req_valid;
            if (busy && !resp_valid && cin_q.size() > 0)
                check("pipe_cin", slice_cin, cin_q.pop_front());
            if (resp_valid && exp_q.size() > 0) begin
                check("pipe_resp", {resp_sum, resp_cout, resp_ovf}, exp_q.pop_front());
                done++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (k > 0) check("pipe_gap", cyc - last_acc, 6);
                last_acc = cyc;
                k++;
                if (k < 3) begin
                    req_a = pa[k]; req_b = pb[k]; req_sub = ps[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("pipe_done", done, 3);
        check("pipe_accepts", k, 3);
        resp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 1'b0;
        resp_ready = 1'b0;
        repeat (3) tick();
        // Reset state.
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_flags", {resp_valid, busy}, 2'b00);
        check("rst_resp", {resp_sum, resp_cout, resp_ovf}, '0);
        check("rst_slice", {slice_a, slice_b, slice_cin}, 17'd0);
        rst_n = 1'b1;
        tick();

        // Add with full carry ripple and carry out.
        push_exp(32'h0000_0000, 1'b1, 1'b0, 4'b1110);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        // Add with signed overflow.
        push_exp(32'h8000_0000, 1'b0, 1'b1, 4'b1110);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        // Subtract with borrow.
        push_exp(32'hFFFF_FFFE, 1'b0, 1'b0, 4'b0001);
        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        // Subtract with signed overflow.
        push_exp(32'h7FFF_FFFF, 1'b1, 1'b1, 4'b0001);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        // Backpressure: three stall cycles in DONE.
        push_exp(32'h0000_0100, 1'b0, 1'b0, 4'b0010);
        run_op("backpress", 32'h0000_00FF, 32'h0000_0001, 1'b0, 3);

        // Reset in the middle of RUN (idx = 2) aborts with no response.
        req_valid = 1'b1;
        req_a     = 32'hAAAA_AAAA;
        req_b     = 32'h5555_5555;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_idle", {req_ready, busy, resp_valid}, 3'b100);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        push_exp(32'h1122_3344, 1'b0, 1'b0, 4'b0000);
        run_op("after_abort", 32'h0102_0304, 32'h1020_3040, 1'b0, 0);

        // Back-to-back operations.
        pipe_test();

        check("queues_drained", exp_q.size() + cin_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
